// File: rtl/riscv_instr_mem_arbiter.sv
// Two-master instruction-memory arbiter (m0 = core fetch, m1 = debug/loader) with lock-on-stall and in-order response routing.
// Define INSTR_ARB_ROUND_ROBIN_EN for round-robin selection; fixed m0 priority otherwise.
module riscv_instr_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] count_q, count_d;
  logic          lock_q, lock_d;
  master_e       lock_id_q, lock_id_d;
  logic          err_q, err_d;
  master_e       sel_id;
  master_e       head_id;
  logic          push;
  logic          pop;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  master_e ptr_q, ptr_d;
`endif

  // A stalled request keeps its master selected until the memory grants it.
  always_comb begin
    sel_id = M0;
    if (lock_q) begin
      sel_id = lock_id_q;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
    end else if (m0_req_i && m1_req_i) begin
      sel_id = ptr_q;
    end else if (m1_req_i) begin
      sel_id = M1;
`else
    end else if (!m0_req_i && m1_req_i) begin
      sel_id = M1;
`endif
    end
  end

  assign instr_req_o  = !rst && (m0_req_i || m1_req_i) && (count_q < MAX_CNT);
  assign instr_addr_o = (sel_id == M1) ? m1_addr_i : m0_addr_i;
  assign push         = instr_req_o && instr_gnt_i;
  assign pop          = !rst && instr_rvalid_i && (count_q != '0);

  assign m0_gnt_o     = push && (sel_id == M0);
  assign m1_gnt_o     = push && (sel_id == M1);
  assign m0_rvalid_o  = pop && (head_id == M0);
  assign m1_rvalid_o  = pop && (head_id == M1);
  assign m0_rdata_o   = rst ? '0 : instr_rdata_i;
  assign m1_rdata_o   = rst ? '0 : instr_rdata_i;
  assign busy_o       = (count_q != '0) || m0_req_i || m1_req_i;
  assign err_o        = err_q;

  always_comb begin
    count_d   = count_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    if (push) begin
      lock_d = 1'b0;
    end else if (instr_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end
    if (instr_rvalid_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (sel_id == M0) ? M1 : M0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= M0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  if (MAX_OUTSTANDING == 1) begin : g_single
    master_e id_q;

    // NOTE: ID storage is not reset; count_q alone decides whether an entry is valid.
    always_ff @(posedge clk) begin
      if (push) begin
        id_q <= sel_id;
      end
    end

    assign head_id = id_q;
  end else begin : g_fifo
    localparam int PW = $clog2(MAX_OUTSTANDING);

    master_e       id_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= sel_id;
      end
    end

    assign head_id = id_mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_riscv_instr_mem_arbiter.sv
// Directed bench for riscv_instr_mem_arbiter: queue-based reference model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_riscv_instr_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;
  localparam bit T    = 1'b1;
  localparam bit F    = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic          m0_gnt_o, m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;
  logic          m1_req_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic          m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;
  logic          instr_req_o;
  logic [AW-1:0] instr_addr_o;
  logic          instr_gnt_i = 1'b0;
  logic          instr_rvalid_i = 1'b0;
  logic [DW-1:0] instr_rdata_i = '0;
  logic          busy_o, err_o;

  always #5 clk = ~clk;

  riscv_instr_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of issuing masters in grant order plus lock/err state.
  int            m_q[$];
  bit            m_lock = 1'b0;
  int            m_lock_id = 0;
  logic [AW-1:0] m_lock_addr = '0;
  bit            m_err = 1'b0;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
  int            m_ptr = 0;
`endif
  bit            e_req;
  int            e_sel;
  bit            e_pop;
  int            e_pop_id;

  function automatic void eval();
    e_req = !rst && (m0_req_i || m1_req_i) && (m_q.size() < MAXO);
    if (m_lock) e_sel = m_lock_id;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
    else if (m0_req_i && m1_req_i) e_sel = m_ptr;
`endif
    else e_sel = m0_req_i ? 0 : 1;
    e_pop    = !rst && instr_rvalid_i && (m_q.size() > 0);
    e_pop_id = e_pop ? m_q[0] : 0;
  endfunction

  always @(posedge clk) begin
    if (!rst && m_lock) begin
      assert (m_lock_id == 0 ? (m0_req_i && m0_addr_i == m_lock_addr)
                             : (m1_req_i && m1_addr_i == m_lock_addr))
        else $error("locked master dropped or changed its request");
    end
    eval();
    if (rst) begin
      m_q.delete();
      m_lock = 1'b0;
      m_err  = 1'b0;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
      m_ptr  = 0;
`endif
    end else begin
      if (instr_rvalid_i && m_q.size() == 0) m_err = 1'b1;
      if (e_pop) void'(m_q.pop_front());
      if (e_req && instr_gnt_i) begin
        m_q.push_back(e_sel);
        m_lock = 1'b0;
`ifdef INSTR_ARB_ROUND_ROBIN_EN
        m_ptr  = 1 - e_sel;
`endif
      end else if (e_req) begin
        m_lock      = 1'b1;
        m_lock_id   = e_sel;
        m_lock_addr = (e_sel == 1) ? m1_addr_i : m0_addr_i;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      eval();
      check("instr_req", 64'(instr_req_o), 64'(e_req));
      if (e_req) check("instr_addr", 64'(instr_addr_o), 64'((e_sel == 1) ? m1_addr_i : m0_addr_i));
      check("m0_gnt", 64'(m0_gnt_o), 64'(e_req && instr_gnt_i && e_sel == 0));
      check("m1_gnt", 64'(m1_gnt_o), 64'(e_req && instr_gnt_i && e_sel == 1));
      check("m0_rvalid", 64'(m0_rvalid_o), 64'(e_pop && e_pop_id == 0));
      check("m1_rvalid", 64'(m1_rvalid_o), 64'(e_pop && e_pop_id == 1));
      check("m0_rdata", 64'(m0_rdata_o), rst ? 64'd0 : 64'(instr_rdata_i));
      check("m1_rdata", 64'(m1_rdata_o), rst ? 64'd0 : 64'(instr_rdata_i));
      check("busy", 64'(busy_o), 64'(m_q.size() != 0 || m0_req_i || m1_req_i));
      check("err", 64'(err_o), 64'(m_err));
    end
  end

  task automatic step(input bit r, input bit r0, input logic [AW-1:0] a0,
                      input bit r1, input logic [AW-1:0] a1,
                      input bit g, input bit rv, input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    rst            = r;
    m0_req_i       = r0;
    m0_addr_i      = a0;
    m1_req_i       = r1;
    m1_addr_i      = a1;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    #2;
  endtask

  bit exp0;

  initial begin
    // Reset cycles with activity on every input: outputs must stay quiet.
    step(T, T, 32'h80, F, 0, T, T, 32'hdead_beef);
    cmp_en = 1'b1;
    check("rst_m0_gnt", 64'(m0_gnt_o), 64'd0);
    check("rst_m0_rdata", 64'(m0_rdata_o), 64'd0);
    check("rst_instr_req", 64'(instr_req_o), 64'd0);
    step(T, F, 0, F, 0, F, F, 0);
    step(F, F, 0, F, 0, F, F, 0);
    check("reset_err", 64'(err_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);

    // Single core fetch.
    step(F, T, 32'h0000_0080, F, 0, T, F, 0);
    check("t1_m0_gnt", 64'(m0_gnt_o), 64'd1);
    check("t1_addr", 64'(instr_addr_o), 64'h80);
    step(F, F, 0, F, 0, F, T, 32'h0000_0013);
    check("t1_m0_rvalid", 64'(m0_rvalid_o), 64'd1);
    check("t1_m0_rdata", 64'(m0_rdata_o), 64'h13);
    check("t1_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
    step(F, F, 0, F, 0, F, F, 0);
    check("t1_busy", 64'(busy_o), 64'd0);

    // Both masters requesting every cycle.
    step(T, F, 0, F, 0, F, F, 0);
    for (int i = 0; i < 4; i++) begin
      step(F, T, 32'h100 + 32'(4 * i), T, 32'h900 + 32'(4 * i), T, i > 0, 32'(i));
`ifdef INSTR_ARB_ROUND_ROBIN_EN
      exp0 = (i % 2) == 0;
`else
      exp0 = 1'b1;
`endif
      check("t2_m0_gnt", 64'(m0_gnt_o), 64'(exp0));
      check("t2_m1_gnt", 64'(m1_gnt_o), 64'(!exp0));
    end
    step(F, F, 0, F, 0, F, T, 32'h44);
`ifdef INSTR_ARB_ROUND_ROBIN_EN
    check("t2_last_m1_rvalid", 64'(m1_rvalid_o), 64'd1);
`else
    check("t2_last_m0_rvalid", 64'(m0_rvalid_o), 64'd1);
`endif

    // Lock under stall: m1 stalls, m0 joins, m1 keeps the port.
    step(F, F, 0, T, 32'h200, F, F, 0);
    check("t3_addr_c0", 64'(instr_addr_o), 64'h200);
    step(F, T, 32'h100, T, 32'h200, F, F, 0);
    check("t3_addr_c1", 64'(instr_addr_o), 64'h200);
    step(F, T, 32'h100, T, 32'h200, F, F, 0);
    check("t3_addr_c2", 64'(instr_addr_o), 64'h200);
    step(F, T, 32'h100, T, 32'h200, T, F, 0);
    check("t3_m1_gnt", 64'(m1_gnt_o), 64'd1);
    check("t3_m0_gnt_c3", 64'(m0_gnt_o), 64'd0);
    check("t3_addr_c3", 64'(instr_addr_o), 64'h200);
    step(F, T, 32'h104, F, 0, T, F, 0);
    check("t3_m0_gnt_c4", 64'(m0_gnt_o), 64'd1);
    // Full: the pop this cycle must not open a slot.
    step(F, T, 32'h108, F, 0, T, T, 32'haa);
    check("t3_full_noreq", 64'(instr_req_o), 64'd0);
    check("t3_m1_rvalid", 64'(m1_rvalid_o), 64'd1);
    // Push and pop together at count 1.
    step(F, T, 32'h108, F, 0, T, T, 32'hbb);
    check("t3_pp_gnt", 64'(m0_gnt_o), 64'd1);
    check("t3_pp_rvalid", 64'(m0_rvalid_o), 64'd1);
    step(F, F, 0, F, 0, F, T, 32'hcc);
    check("t3_pp_count", 64'(m_q.size()), 64'd1);
    check("t3_pp_rvalid2", 64'(m0_rvalid_o), 64'd1);
    check("t3_pp_err", 64'(err_o), 64'd0);
    step(F, F, 0, F, 0, F, F, 0);

    // Outstanding limit with late responses, m0/m1 interleaved.
    step(F, T, 32'h300, F, 0, T, F, 0);
    check("t4_m0_gnt", 64'(m0_gnt_o), 64'd1);
    step(F, F, 0, T, 32'h400, T, F, 0);
    check("t4_m1_gnt", 64'(m1_gnt_o), 64'd1);
    step(F, T, 32'h304, T, 32'h404, T, F, 0);
    check("t4_limit_c2", 64'(instr_req_o), 64'd0);
    step(F, T, 32'h304, T, 32'h404, T, F, 0);
    check("t4_limit_c3", 64'(instr_req_o), 64'd0);
    step(F, T, 32'h304, T, 32'h404, T, T, 32'h1);
    check("t4_limit_c4", 64'(instr_req_o), 64'd0);
    check("t4_rv_m0", 64'(m0_rvalid_o), 64'd1);
    step(F, T, 32'h304, T, 32'h404, T, T, 32'h2);
    check("t4_rv_m1", 64'(m1_rvalid_o), 64'd1);
    check("t4_regrant", 64'(m0_gnt_o), 64'd1);
    step(F, F, 0, F, 0, F, T, 32'h3);
    check("t4_rv_m0_last", 64'(m0_rvalid_o), 64'd1);
    step(F, F, 0, F, 0, F, F, 0);

    // Spurious response with nothing outstanding.
    step(F, F, 0, F, 0, F, T, 32'h55);
    check("t5_no_m0_rvalid", 64'(m0_rvalid_o), 64'd0);
    check("t5_no_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
    check("t5_rdata_pass", 64'(m0_rdata_o), 64'h55);
    step(F, F, 0, F, 0, F, F, 0);
    check("t5_err_set", 64'(err_o), 64'd1);
    step(F, F, 0, F, 0, F, F, 0);
    check("t5_err_sticky", 64'(err_o), 64'd1);
    step(T, F, 0, F, 0, F, F, 0);
    step(F, F, 0, F, 0, F, F, 0);
    check("t5_err_clear", 64'(err_o), 64'd0);

    // Reset mid-transaction: the late response is stale.
    step(F, T, 32'h500, F, 0, T, F, 0);
    check("t5_pre_gnt", 64'(m0_gnt_o), 64'd1);
    step(T, F, 0, F, 0, F, F, 0);
    step(F, F, 0, F, 0, F, T, 32'h66);
    check("t5_stale_rvalid", 64'(m0_rvalid_o), 64'd0);
    step(F, F, 0, F, 0, F, F, 0);
    check("t5_stale_err", 64'(err_o), 64'd1);
    step(T, F, 0, F, 0, F, F, 0);
    step(F, F, 0, F, 0, F, F, 0);
    check("t5_final_err", 64'(err_o), 64'd0);

    step(F, F, 0, F, 0, F, F, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
